// File: rtl/ps2_voice_controller.sv
// Polyphonic PS/2 note controller: allocates key presses to tone voices,
// tracks voice age for stealing, and lets released voices finish their period.
module ps2_voice_controller #(
   parameter int CHANNELS  = 4,
   parameter int CODE_W    = 8,
   parameter int STOP_CODE = 99,
   parameter int STEAL     = 1
) (
   input  logic                       iClk,
   input  logic                       iReset,
   input  logic                       iKey_Valid,
   input  logic [CODE_W-1:0]          iKey_Code,
   input  logic                       iKey_Release,
   input  logic [CHANNELS-1:0]        iCycle_Done,
   output logic [CHANNELS*CODE_W-1:0] oChan_Code,
   output logic [CHANNELS-1:0]        oChan_Enable,
   output logic                       oDrop
);

   localparam int IW = $clog2(CHANNELS);

   // bit 0 of the state doubles as the voice count-enable
   localparam logic [1:0] IDLE     = 2'b00;
   localparam logic [1:0] PLAYING  = 2'b01;
   localparam logic [1:0] STOPPING = 2'b11;

   logic [1:0]          state [CHANNELS];
   logic [CODE_W-1:0]   code  [CHANNELS];
   logic [IW-1:0]       rank  [CHANNELS];

   logic [CHANNELS-1:0] hit_play, hit_stop, idle;
   logic [IW-1:0]       free_idx, old_idx, stop_idx, alloc_idx, old_rank;
   logic                is_press, stop_all, note_press, key_rel;
   logic                do_retrig, do_alloc, do_drop;

   always_comb begin
      hit_play = '0;
      hit_stop = '0;
      idle     = '0;
      free_idx = '0;
      old_idx  = '0;
      stop_idx = '0;
      // descending scan so the lowest matching index wins
      for (int k = CHANNELS - 1; k >= 0; k--) begin
         hit_play[k] = (state[k] == PLAYING) && (code[k] == iKey_Code);
         hit_stop[k] = (state[k] == STOPPING) && (code[k] == iKey_Code);
         idle[k]     = (state[k] == IDLE);
         if (idle[k]) free_idx = IW'(k);
         if (hit_stop[k]) stop_idx = IW'(k);
         if (rank[k] == IW'(CHANNELS - 1)) old_idx = IW'(k);
      end
      is_press   = iKey_Valid & ~iKey_Release;
      stop_all   = is_press && (iKey_Code == CODE_W'(STOP_CODE));
      note_press = is_press & ~stop_all;
      key_rel    = iKey_Valid & iKey_Release;
      do_retrig  = note_press & ~|hit_play & |hit_stop;
      do_alloc   = note_press & ~|hit_play & ~|hit_stop
                   & (|idle | (STEAL != 0));
      do_drop    = note_press & ~|hit_play & ~|hit_stop
                   & ~|idle & (STEAL == 0);
      alloc_idx  = (|idle) ? free_idx : old_idx;
      old_rank   = rank[alloc_idx];
   end

   always_ff @(posedge iClk or posedge iReset) begin
      if (iReset) begin
         oDrop <= 1'b0;
         for (int k = 0; k < CHANNELS; k++) begin
            state[k] <= IDLE;
            code[k]  <= '0;
            rank[k]  <= IW'(k);
         end
      end else begin
         oDrop <= do_drop;
         for (int k = 0; k < CHANNELS; k++) begin
            case (state[k])
               IDLE: begin
                  if (do_alloc && alloc_idx == IW'(k)) begin
                     state[k] <= PLAYING;
                     code[k]  <= iKey_Code;
                  end
               end
               PLAYING: begin
                  if (do_alloc && alloc_idx == IW'(k))
                     code[k] <= iKey_Code;
                  else if (stop_all || (key_rel && hit_play[k]))
                     state[k] <= STOPPING;
               end
               STOPPING: begin
                  if (do_retrig && stop_idx == IW'(k)) begin
                     state[k] <= PLAYING;
                  end else if (do_alloc && alloc_idx == IW'(k)) begin
                     state[k] <= PLAYING;
                     code[k]  <= iKey_Code;
                  end else if (iCycle_Done[k]) begin
                     state[k] <= IDLE;
                  end
               end
               default: state[k] <= IDLE;
            endcase
            if (do_alloc) begin
               if (alloc_idx == IW'(k))
                  rank[k] <= '0;
               else if (rank[k] < old_rank)
                  rank[k] <= rank[k] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      for (int k = 0; k < CHANNELS; k++) begin
         oChan_Enable[k]                 = state[k][0];
         oChan_Code[k*CODE_W +: CODE_W]  = code[k];
      end
   end

endmodule

// File: tb/tb_ps2_voice_controller.sv
// Directed bench for ps2_voice_controller; a stealing and a dropping
// instance share the same stimulus.
module tb_ps2_voice_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        kv = 1'b0;
   logic [7:0]  kc = '0;
   logic        kr = 1'b0;
   logic [3:0]  done = '0;

   logic [31:0] code_a, code_b;
   logic [3:0]  en_a, en_b;
   logic        drop_a, drop_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ps2_voice_controller #(.CHANNELS(4), .CODE_W(8), .STOP_CODE(99), .STEAL(1)) dut_a (
      .iClk(clk), .iReset(rst), .iKey_Valid(kv), .iKey_Code(kc),
      .iKey_Release(kr), .iCycle_Done(done), .oChan_Code(code_a),
      .oChan_Enable(en_a), .oDrop(drop_a)
   );

   ps2_voice_controller #(.CHANNELS(4), .CODE_W(8), .STOP_CODE(99), .STEAL(0)) dut_b (
      .iClk(clk), .iReset(rst), .iKey_Valid(kv), .iKey_Code(kc),
      .iKey_Release(kr), .iCycle_Done(done), .oChan_Code(code_b),
      .oChan_Enable(en_b), .oDrop(drop_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic ev(input logic v, input logic [7:0] c, input logic r, input logic [3:0] d);
      kv = v; kc = c; kr = r; done = d;
      @(posedge clk);
      #1;
      kv = 1'b0; kc = '0; kr = 1'b0; done = '0;
   endtask

   task automatic press(input logic [7:0] c);
      ev(1'b1, c, 1'b0, 4'b0000);
   endtask

   task automatic rel(input logic [7:0] c);
      ev(1'b1, c, 1'b1, 4'b0000);
   endtask

   task automatic pulse(input logic [3:0] d);
      ev(1'b0, 8'h00, 1'b0, d);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      @(posedge clk);
      #1;
      chk("reset_en", {28'd0, en_a}, 32'h0);
      chk("reset_code", code_a, 32'h0);
      chk("reset_drop", {31'd0, drop_b}, 32'h0);
      rst = 1'b0;

      // single note, release waits for a period end
      press(8'h15);
      chk("press_en", {28'd0, en_a}, 32'h1);
      chk("press_code", code_a, 32'h0000_0015);
      rel(8'h15);
      chk("rel_en_hold", {28'd0, en_a}, 32'h1);
      pulse(4'b0000);
      chk("rel_en_wait", {28'd0, en_a}, 32'h1);
      pulse(4'b0001);
      chk("rel_en_done", {28'd0, en_a}, 32'h0);
      chk("rel_code_hold", code_a, 32'h0000_0015);

      // fill all voices, then steal or drop
      do_reset();
      press(8'h15);
      press(8'h1D);
      press(8'h24);
      press(8'h2D);
      chk("full_en", {28'd0, en_a}, 32'hF);
      chk("full_code", code_a, 32'h2D24_1D15);
      press(8'h2C);
      chk("steal_en", {28'd0, en_a}, 32'hF);
      chk("steal_code", code_a, 32'h2D24_1D2C);
      chk("steal_nodrop", {31'd0, drop_a}, 32'h0);
      chk("drop_pulse", {31'd0, drop_b}, 32'h1);
      chk("drop_code", code_b, 32'h2D24_1D15);
      chk("drop_en", {28'd0, en_b}, 32'hF);
      pulse(4'b0000);
      chk("drop_once", {31'd0, drop_b}, 32'h0);
      // oldest is now voice 1 on the stealing instance
      press(8'h3C);
      chk("steal2_code", code_a, 32'h2D24_3C2C);

      // repeat, retrigger and retrigger beating a period end
      do_reset();
      press(8'h15);
      press(8'h15);
      chk("repeat_en", {28'd0, en_a}, 32'h1);
      chk("repeat_code", code_a, 32'h0000_0015);
      rel(8'h15);
      press(8'h15);
      pulse(4'b0001);
      chk("retrig_en", {28'd0, en_a}, 32'h1);
      pulse(4'b0001);
      chk("retrig_en2", {28'd0, en_a}, 32'h1);
      rel(8'h15);
      ev(1'b1, 8'h15, 1'b0, 4'b0001);
      chk("retrig_vs_done", {28'd0, en_a}, 32'h1);
      pulse(4'b0001);
      chk("retrig_vs_done2", {28'd0, en_a}, 32'h1);

      // stop code, independent period ends
      do_reset();
      press(8'h15);
      press(8'h1D);
      press(8'h24);
      rel(8'd99);
      chk("stoprel_ignored", {28'd0, en_a}, 32'h7);
      press(8'd99);
      chk("stop_en", {28'd0, en_a}, 32'h7);
      pulse(4'b0101);
      chk("stop_done_0101", {28'd0, en_a}, 32'h2);
      pulse(4'b0010);
      chk("stop_done_0010", {28'd0, en_a}, 32'h0);

      // period end in the same cycle as the release does not count
      do_reset();
      press(8'h15);
      press(8'h1D);
      ev(1'b1, 8'h1D, 1'b1, 4'b0010);
      chk("rel_same_done", {28'd0, en_a}, 32'h3);
      pulse(4'b0000);
      chk("rel_same_wait", {28'd0, en_a}, 32'h3);
      pulse(4'b0010);
      chk("rel_later_done", {28'd0, en_a}, 32'h1);

      // asynchronous reset while all voices are stopping
      do_reset();
      press(8'h15);
      press(8'h1D);
      press(8'h24);
      press(8'h2D);
      press(8'd99);
      chk("mid_stop_en", {28'd0, en_a}, 32'hF);
      #3;
      rst = 1'b1;
      #1;
      chk("async_rst_en", {28'd0, en_a}, 32'h0);
      chk("async_rst_code", code_a, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      press(8'h30);
      chk("post_rst_en", {28'd0, en_a}, 32'h1);
      chk("post_rst_code", code_a, 32'h0000_0030);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
